// File: rtl/exe_decode_pipe.sv
// exe_decode_pipe: registered multi-lane execute-stage control decoder.
//
// Each cycle a bundle of up to LANES micro-ops is accepted from dispatch. Per lane the
// micro-opcode is decoded into the execute control tuple {alufn, opr1, opr2, cmpfn}, the
// 20-bit packed immediate is expanded to XLEN bits and unknown opcodes are flagged. The
// decoded bundle is presented downstream through valid/ready with a one-entry skid buffer.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush          synchronous kill of held and incoming bundles
//   in_valid/in_ready, in_lane_vld, in_uopc, in_imm_packed, in_imm_type, in_tag
//                  input bundle from rename/dispatch
//   out_valid/out_ready, out_lane_vld, out_ctrl, out_imm, out_tag, out_illegal
//                  decoded bundle to the execute stage

package rv32i_types;

  typedef enum logic [5:0] {
    UopLui   = 6'd0,
    UopAuipc = 6'd1,
    UopJalr  = 6'd2,
    UopBeq   = 6'd3,
    UopBne   = 6'd4,
    UopBlt   = 6'd5,
    UopBge   = 6'd6,
    UopBltu  = 6'd7,
    UopBgeu  = 6'd8,
    UopAddi  = 6'd9,
    UopSlti  = 6'd10,
    UopSltiu = 6'd11,
    UopXori  = 6'd12,
    UopOri   = 6'd13,
    UopAndi  = 6'd14,
    UopSlli  = 6'd15,
    UopSrli  = 6'd16,
    UopSrai  = 6'd17,
    UopAdd   = 6'd18,
    UopSub   = 6'd19,
    UopSll   = 6'd20,
    UopSlt   = 6'd21,
    UopSltu  = 6'd22,
    UopXor   = 6'd23,
    UopSrl   = 6'd24,
    UopSra   = 6'd25,
    UopOr    = 6'd26,
    UopAnd   = 6'd27
  } uopc_t;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alufn_t;

  typedef enum logic [1:0] {Opr1Rs1, Opr1Pc, Opr1Zero} opr1_t;

  typedef enum logic [0:0] {Opr2Rs2, Opr2Imm} opr2_t;

  typedef enum logic [2:0] {
    CmpNone, CmpEq, CmpNe, CmpLt, CmpGe, CmpLtu, CmpGeu, CmpJalr
  } cmpfn_t;

  typedef struct packed {
    alufn_t alufn;
    opr1_t  opr1;
    opr2_t  opr2;
    cmpfn_t cmpfn;
  } exe_ctrl_t;

endpackage

package immt;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_t;

endpackage

module exe_decode_pipe
  import rv32i_types::*;
  import immt::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned TAG_W = 6,
  // Only 32 is supported; the immediate expansion is written for rv32i.
  parameter int unsigned XLEN  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES-1:0]                  in_lane_vld,
  input  uopc_t     [LANES-1:0]             in_uopc,
  input  logic      [LANES-1:0][19:0]       in_imm_packed,
  input  imm_type_t [LANES-1:0]             in_imm_type,
  input  logic      [LANES-1:0][TAG_W-1:0]  in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0]                  out_lane_vld,
  output exe_ctrl_t [LANES-1:0]             out_ctrl,
  output logic      [LANES-1:0][XLEN-1:0]   out_imm,
  output logic      [LANES-1:0][TAG_W-1:0]  out_tag,
  output logic [LANES-1:0]                  out_illegal
);

  typedef struct packed {
    logic [LANES-1:0]                 lane_vld;
    exe_ctrl_t [LANES-1:0]            ctrl;
    logic      [LANES-1:0][XLEN-1:0]  imm;
    logic      [LANES-1:0][TAG_W-1:0] tag;
    logic [LANES-1:0]                 illegal;
  } bundle_t;

  // StEmpty: OUT invalid; StOne: OUT valid, SKID empty; StFull: both valid.
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_t;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  function automatic alufn_t alu_of(input uopc_t u);
    alufn_t a;
    case (u)
      UopSub:           a = AluSub;
      UopSll,  UopSlli: a = AluSll;
      UopSlt,  UopSlti: a = AluSlt;
      UopSltu, UopSltiu: a = AluSltu;
      UopXor,  UopXori: a = AluXor;
      UopSrl,  UopSrli: a = AluSrl;
      UopSra,  UopSrai: a = AluSra;
      UopOr,   UopOri:  a = AluOr;
      UopAnd,  UopAndi: a = AluAnd;
      default:          a = AluAdd;
    endcase
    return a;
  endfunction

  // Unknown opcodes fall back to the lui tuple {add, zero, imm, none}.
  function automatic exe_ctrl_t decode_ctrl(input uopc_t u, output logic legal);
    exe_ctrl_t c;
    c.alufn = AluAdd;
    c.opr1  = Opr1Zero;
    c.opr2  = Opr2Imm;
    c.cmpfn = CmpNone;
    legal   = 1'b1;
    case (u)
      UopLui: begin
      end
      UopAuipc: c.opr1 = Opr1Pc;
      UopJalr: begin
        c.opr1  = Opr1Rs1;
        c.cmpfn = CmpJalr;
      end
      UopBeq:  begin c.opr1 = Opr1Pc; c.cmpfn = CmpEq;  end
      UopBne:  begin c.opr1 = Opr1Pc; c.cmpfn = CmpNe;  end
      UopBlt:  begin c.opr1 = Opr1Pc; c.cmpfn = CmpLt;  end
      UopBge:  begin c.opr1 = Opr1Pc; c.cmpfn = CmpGe;  end
      UopBltu: begin c.opr1 = Opr1Pc; c.cmpfn = CmpLtu; end
      UopBgeu: begin c.opr1 = Opr1Pc; c.cmpfn = CmpGeu; end
      UopAddi, UopSlti, UopSltiu, UopXori, UopOri, UopAndi,
      UopSlli, UopSrli, UopSrai: begin
        c.opr1  = Opr1Rs1;
        c.alufn = alu_of(u);
      end
      UopAdd, UopSub, UopSll, UopSlt, UopSltu, UopXor,
      UopSrl, UopSra, UopOr, UopAnd: begin
        c.opr1  = Opr1Rs1;
        c.opr2  = Opr2Rs2;
        c.alufn = alu_of(u);
      end
      default: legal = 1'b0;
    endcase
    return c;
  endfunction

  // Packed layout: p[19] sign, p[18:9] imm[10:1], p[8] imm[11] (B/J) or imm[0] (I/S),
  // p[7:0] imm[19:12] (J). U takes p as imm[31:12] verbatim.
  function automatic logic [31:0] expand_imm(input logic [19:0] p, input imm_type_t t);
    logic        s;
    logic [31:0] imm;
    s = p[19];
    case (t)
      ImmB:    imm = {{20{s}}, p[8], p[18:9], 1'b0};
      ImmU:    imm = {p, 12'b0};
      ImmJ:    imm = {{12{s}}, p[7:0], p[8], p[18:9], 1'b0};
      default: imm = {{21{s}}, p[18:9], p[8]};
    endcase
    return imm;
  endfunction

  // ---------------------------------------------------------------------------
  // Input-side decode
  // ---------------------------------------------------------------------------
  bundle_t dec;

  always_comb begin
    logic legal;
    dec          = '0;
    legal        = 1'b1;
    dec.lane_vld = in_lane_vld;
    for (int l = 0; l < LANES; l++) begin
      dec.ctrl[l]    = decode_ctrl(in_uopc[l], legal);
      // Empty lanes still decode but never report illegal.
      dec.illegal[l] = in_lane_vld[l] & ~legal;
      dec.imm[l]     = expand_imm(in_imm_packed[l], in_imm_type[l]);
      dec.tag[l]     = in_tag[l];
    end
  end

  // ---------------------------------------------------------------------------
  // Output register + skid buffer
  // ---------------------------------------------------------------------------
  state_t  state_q, state_d;
  bundle_t out_q, skid_q;
  logic    accept;
  logic    out_load, out_from_skid, skid_load;

  // in_ready comes straight from state so it never depends on out_ready.
  assign in_ready = (state_q != StFull);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d       = state_q;
    out_load      = 1'b0;
    out_from_skid = 1'b0;
    skid_load     = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            out_load = 1'b1;
            state_d  = StOne;
          end
        end
        StOne: begin
          if (out_ready) begin
            if (accept) out_load = 1'b1;
            else        state_d  = StEmpty;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = StFull;
          end
        end
        StFull: begin
          if (out_ready) begin
            out_from_skid = 1'b1;
            state_d       = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (out_load)           out_q <= dec;
      else if (out_from_skid) out_q <= skid_q;
      if (skid_load)          skid_q <= dec;
    end
  end

  assign out_valid    = (state_q != StEmpty);
  assign out_lane_vld = out_q.lane_vld;
  assign out_ctrl     = out_q.ctrl;
  assign out_imm      = out_q.imm;
  assign out_tag      = out_q.tag;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_exe_decode_pipe.sv
// Directed bench for exe_decode_pipe: reset, decode/immediate table, illegal opcodes,
// back-pressure through the skid buffer, flush and asynchronous reset mid-stall.

module tb_exe_decode_pipe;
  import rv32i_types::*;
  import immt::*;

  localparam int unsigned LANES = 2;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned XLEN  = 32;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic                              flush;
  logic                              in_valid;
  logic                              in_ready;
  logic [LANES-1:0]                  in_lane_vld;
  uopc_t     [LANES-1:0]             in_uopc;
  logic      [LANES-1:0][19:0]       in_imm_packed;
  imm_type_t [LANES-1:0]             in_imm_type;
  logic      [LANES-1:0][TAG_W-1:0]  in_tag;
  logic                              out_valid;
  logic                              out_ready;
  logic [LANES-1:0]                  out_lane_vld;
  exe_ctrl_t [LANES-1:0]             out_ctrl;
  logic      [LANES-1:0][XLEN-1:0]   out_imm;
  logic      [LANES-1:0][TAG_W-1:0]  out_tag;
  logic [LANES-1:0]                  out_illegal;

  int checks = 0;
  int errors = 0;

  logic        log_en = 1'b0;
  int unsigned log_q[$];

  exe_decode_pipe #(.LANES(LANES), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_lane_vld  (in_lane_vld),
    .in_uopc      (in_uopc),
    .in_imm_packed(in_imm_packed),
    .in_imm_type  (in_imm_type),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane_vld (out_lane_vld),
    .out_ctrl     (out_ctrl),
    .out_imm      (out_imm),
    .out_tag      (out_tag),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  // Record lane-0 tags of every downstream handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (log_en && out_valid && out_ready) log_q.push_back(int'(out_tag[0]));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input uopc_t u, input logic [19:0] p,
                          input imm_type_t t, input logic [TAG_W-1:0] tag);
    in_uopc[l]       = u;
    in_imm_packed[l] = p;
    in_imm_type[l]   = t;
    in_tag[l]        = tag;
  endtask

  function automatic exe_ctrl_t ctl(input alufn_t a, input opr1_t o1, input opr2_t o2,
                                    input cmpfn_t c);
    exe_ctrl_t r;
    r.alufn = a;
    r.opr1  = o1;
    r.opr2  = o2;
    r.cmpfn = c;
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_lane_vld !== 2'b00) begin errors++;
      $display("FAIL rst_lane_vld got %b exp 00", out_lane_vld); end
    checks++; if (out_illegal !== 2'b00) begin errors++;
      $display("FAIL rst_illegal got %b exp 00", out_illegal); end
    checks++; if (out_ctrl !== '0) begin errors++;
      $display("FAIL rst_ctrl got %h exp 0", out_ctrl); end
    checks++; if (out_imm !== '0) begin errors++;
      $display("FAIL rst_imm got %h exp 0", out_imm); end
    checks++; if (out_tag !== '0) begin errors++;
      $display("FAIL rst_tag got %h exp 0", out_tag); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_decode;
    uopc_t       v_u[10];
    logic [19:0] v_p[10];
    imm_type_t   v_t[10];
    exe_ctrl_t   v_c[10];
    logic [31:0] v_i[10];
    int          j;
    v_u[0] = UopAddi;  v_p[0] = 20'hFFFFF; v_t[0] = ImmI; v_i[0] = 32'hFFFF_FFFF;
    v_c[0] = ctl(AluAdd, Opr1Rs1, Opr2Imm, CmpNone);
    v_u[1] = UopLui;   v_p[1] = 20'h12345; v_t[1] = ImmU; v_i[1] = 32'h1234_5000;
    v_c[1] = ctl(AluAdd, Opr1Zero, Opr2Imm, CmpNone);
    v_u[2] = UopBne;   v_p[2] = 20'h80001; v_t[2] = ImmB; v_i[2] = 32'hFFFF_F000;
    v_c[2] = ctl(AluAdd, Opr1Pc, Opr2Imm, CmpNe);
    v_u[3] = UopBgeu;  v_p[3] = 20'h7FF00; v_t[3] = ImmB; v_i[3] = 32'h0000_0FFE;
    v_c[3] = ctl(AluAdd, Opr1Pc, Opr2Imm, CmpGeu);
    v_u[4] = UopAuipc; v_p[4] = 20'h000FF; v_t[4] = ImmJ; v_i[4] = 32'h000F_F000;
    v_c[4] = ctl(AluAdd, Opr1Pc, Opr2Imm, CmpNone);
    v_u[5] = UopJalr;  v_p[5] = 20'h801FF; v_t[5] = ImmJ; v_i[5] = 32'hFFFF_F800;
    v_c[5] = ctl(AluAdd, Opr1Rs1, Opr2Imm, CmpJalr);
    v_u[6] = UopSub;   v_p[6] = 20'h00300; v_t[6] = ImmS; v_i[6] = 32'h0000_0003;
    v_c[6] = ctl(AluSub, Opr1Rs1, Opr2Rs2, CmpNone);
    v_u[7] = UopSrai;  v_p[7] = 20'h40000; v_t[7] = ImmI; v_i[7] = 32'h0000_0400;
    v_c[7] = ctl(AluSra, Opr1Rs1, Opr2Imm, CmpNone);
    v_u[8] = UopBlt;   v_p[8] = 20'hFFFFF; v_t[8] = ImmB; v_i[8] = 32'hFFFF_FFFE;
    v_c[8] = ctl(AluAdd, Opr1Pc, Opr2Imm, CmpLt);
    v_u[9] = UopAnd;   v_p[9] = 20'h00000; v_t[9] = ImmU; v_i[9] = 32'h0000_0000;
    v_c[9] = ctl(AluAnd, Opr1Rs1, Opr2Rs2, CmpNone);

    out_ready   = 1'b1;
    in_lane_vld = 2'b11;
    in_valid    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      j = 9 - i;
      set_lane(0, v_u[i], v_p[i], v_t[i], TAG_W'(i));
      set_lane(1, v_u[j], v_p[j], v_t[j], TAG_W'(32 + i));
      tick;
      checks++; if (out_valid !== 1'b1) begin errors++;
        $display("FAIL dec_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_ctrl[0] !== v_c[i]) begin errors++;
        $display("FAIL dec_ctrl0[%0d] got %h exp %h", i, out_ctrl[0], v_c[i]); end
      checks++; if (out_imm[0] !== v_i[i]) begin errors++;
        $display("FAIL dec_imm0[%0d] got %h exp %h", i, out_imm[0], v_i[i]); end
      checks++; if (out_ctrl[1] !== v_c[j]) begin errors++;
        $display("FAIL dec_ctrl1[%0d] got %h exp %h", i, out_ctrl[1], v_c[j]); end
      checks++; if (out_imm[1] !== v_i[j]) begin errors++;
        $display("FAIL dec_imm1[%0d] got %h exp %h", i, out_imm[1], v_i[j]); end
      checks++; if (out_tag[0] !== TAG_W'(i) || out_tag[1] !== TAG_W'(32 + i)) begin
        errors++;
        $display("FAIL dec_tag[%0d] got %h exp %h/%h", i, out_tag, i, 32 + i); end
      checks++; if (out_illegal !== 2'b00 || out_lane_vld !== 2'b11) begin errors++;
        $display("FAIL dec_flags[%0d] got ill %b vld %b exp 00/11", i, out_illegal,
                 out_lane_vld); end
    end
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL dec_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_illegal;
    uopc_t bad;
    bad         = uopc_t'(6'h3F);
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_lane_vld = 2'b11;
    set_lane(0, UopAddi, 20'h00000, ImmI, 6'd1);
    set_lane(1, bad, 20'h00100, ImmI, 6'd2);
    tick;
    checks++; if (out_illegal !== 2'b10) begin errors++;
      $display("FAIL ill_both got %b exp 10", out_illegal); end
    checks++; if (out_ctrl[1] !== ctl(AluAdd, Opr1Zero, Opr2Imm, CmpNone)) begin errors++;
      $display("FAIL ill_ctrl got %h exp %h", out_ctrl[1],
               ctl(AluAdd, Opr1Zero, Opr2Imm, CmpNone)); end
    checks++; if (out_imm[1] !== 32'h1) begin errors++;
      $display("FAIL ill_imm got %h exp 1", out_imm[1]); end
    in_lane_vld = 2'b01;
    tick;
    checks++; if (out_illegal !== 2'b00 || out_lane_vld !== 2'b01) begin errors++;
      $display("FAIL ill_masked got ill %b vld %b exp 00/01", out_illegal, out_lane_vld); end
    in_lane_vld = 2'b00;
    tick;
    checks++; if (out_valid !== 1'b1 || out_lane_vld !== 2'b00 || out_illegal !== 2'b00)
    begin errors++;
      $display("FAIL empty_bundle got v %b vld %b ill %b exp 1/00/00", out_valid,
               out_lane_vld, out_illegal); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int   n;
    logic acc;
    log_q.delete();
    log_en      = 1'b1;
    out_ready   = 1'b0;
    in_lane_vld = 2'b01;
    in_valid    = 1'b1;
    set_lane(1, UopAddi, 20'h0, ImmI, 6'd0);
    set_lane(0, UopAddi, 20'h0, ImmI, 6'd10);
    tick;
    checks++; if (out_valid !== 1'b1 || out_tag[0] !== 6'd10 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_a got v %b tag %0d rdy %b exp 1/10/1", out_valid, out_tag[0],
               in_ready); end
    set_lane(0, UopAddi, 20'h0, ImmI, 6'd11);
    tick;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    set_lane(0, UopAddi, 20'h0, ImmI, 6'd12);
    tick;
    tick;
    checks++; if (in_ready !== 1'b0 || out_tag[0] !== 6'd10) begin errors++;
      $display("FAIL bp_hold got rdy %b tag %0d exp 0/10", in_ready, out_tag[0]); end
    out_ready = 1'b1;
    n = 0;
    while (n < 10 && (in_valid || out_valid)) begin
      acc = in_valid & in_ready;
      tick;
      if (acc) in_valid = 1'b0;
      n++;
    end
    log_en = 1'b0;
    checks++; if (n >= 10) begin errors++;
      $display("FAIL bp_timeout got %0d cycles exp <10", n); end
    checks++; if (log_q.size() != 3) begin errors++;
      $display("FAIL bp_count got %0d exp 3", log_q.size()); end
    for (int k = 0; k < log_q.size(); k++) begin
      checks++; if (log_q[k] != 10 + k) begin errors++;
        $display("FAIL bp_order[%0d] got %0d exp %0d", k, log_q[k], 10 + k); end
    end
  endtask

  task automatic test_flush;
    log_q.delete();
    out_ready   = 1'b0;
    in_lane_vld = 2'b01;
    in_valid    = 1'b1;
    set_lane(0, UopAdd, 20'h0, ImmI, 6'd20);
    tick;
    set_lane(0, UopAdd, 20'h0, ImmI, 6'd21);
    tick;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++;
      $display("FAIL fl_pre got rdy %b v %b exp 0/1", in_ready, out_valid); end
    set_lane(0, UopAdd, 20'h0, ImmI, 6'd22);
    flush = 1'b1;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL fl_full got v %b rdy %b exp 0/1", out_valid, in_ready); end
    // Flush while empty and ready also drops the incoming bundle.
    in_valid = 1'b1;
    set_lane(0, UopAdd, 20'h0, ImmI, 6'd23);
    flush = 1'b1;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL fl_empty got %b exp 0", out_valid); end
    out_ready = 1'b1;
    log_en    = 1'b1;
    repeat (4) tick;
    log_en = 1'b0;
    checks++; if (log_q.size() != 0 || out_valid !== 1'b0) begin errors++;
      $display("FAIL fl_leak got %0d handshakes v %b exp 0/0", log_q.size(), out_valid); end
  endtask

  task automatic test_async_reset;
    out_ready   = 1'b0;
    in_lane_vld = 2'b01;
    in_valid    = 1'b1;
    set_lane(0, UopOr, 20'h0, ImmI, 6'd30);
    tick;
    set_lane(0, UopOr, 20'h0, ImmI, 6'd31);
    tick;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL ar_pre got rdy %b exp 0", in_ready); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL ar_async got v %b rdy %b exp 0/1", out_valid, in_ready); end
    checks++; if (out_tag !== '0 || out_lane_vld !== 2'b00) begin errors++;
      $display("FAIL ar_data got tag %h vld %b exp 0/00", out_tag, out_lane_vld); end
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_lane(0, UopXor, 20'h0, ImmI, 6'd33);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL ar_idle got %b exp 0", out_valid); end
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_tag[0] !== 6'd33) begin errors++;
      $display("FAIL ar_first got v %b tag %0d exp 1/33", out_valid, out_tag[0]); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL ar_drain got %b exp 0", out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    in_lane_vld   = '0;
    in_uopc       = {UopAddi, UopAddi};
    in_imm_packed = '0;
    in_imm_type   = {ImmI, ImmI};
    in_tag        = '0;
    test_reset();
    test_decode();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
